// File: rtl/psum_pkg.sv
// -----------------------------------------------------------------------------
// psum_pkg
// Shared constants for the partial-sum accumulator and its requantisation
// stage: datapath widths and the signed output clipping limits.
// No ports (package).
// -----------------------------------------------------------------------------
package psum_pkg;

   localparam int IN_W    = 20;  // signed partial sum from the adder tree
   localparam int ACC_W   = 32;  // signed accumulator
   localparam int OUT_W   = 8;   // signed quantised activation
   localparam int CNT_W   = 10;  // channel counter, max num_ch = 2^CNT_W-1
   localparam int BIAS_W  = 16;  // signed per-output bias
   localparam int SHIFT_W = 5;   // requant right shift 0..31

   // Clipping limits for an OUT_W-bit signed activation.
   localparam logic signed [OUT_W-1:0] OUT_MAX = 8'sh7F;   //  127
   localparam logic signed [OUT_W-1:0] OUT_MIN = 8'sh80;   // -128

endpackage : psum_pkg

// File: rtl/psum_requant.sv
// -----------------------------------------------------------------------------
// psum_requant
// Registered requantisation of a finished accumulator value: round-half-up
// arithmetic right shift, optional ReLU, then signed saturation to OUT_W bits.
// A result is registered only in the cycle done_i is high; otherwise the data
// and saturation outputs hold and vld_o stays low.
//
// Ports:
//   clk        in   clock, rising edge
//   rstn       in   asynchronous active-low reset
//   acc_i      in   ACC_W   signed finished accumulator value
//   done_i     in   1       acc_i holds a finished sum this cycle
//   shift_i    in   SHIFT_W right-shift amount for this sum
//   relu_en_i  in   1       clamp negative results to zero
//   data_o     out  OUT_W   signed quantised activation
//   vld_o      out  1       one-cycle pulse per result
//   sat_o      out  1       result was clipped by saturation (with vld_o)
// -----------------------------------------------------------------------------
module psum_requant
   import psum_pkg::*;
#(
   parameter int ACC_W   = psum_pkg::ACC_W,
   parameter int OUT_W   = psum_pkg::OUT_W,
   parameter int SHIFT_W = psum_pkg::SHIFT_W
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic signed [ACC_W-1:0] acc_i,
   input  logic                    done_i,
   input  logic [SHIFT_W-1:0]      shift_i,
   input  logic                    relu_en_i,
   output logic [OUT_W-1:0]        data_o,
   output logic                    vld_o,
   output logic                    sat_o
);

   // Clip limits widened to the rounding datapath width.
   localparam logic signed [ACC_W:0] MAX_X =
      {{(ACC_W+1-OUT_W){OUT_MAX[OUT_W-1]}}, OUT_MAX};
   localparam logic signed [ACC_W:0] MIN_X =
      {{(ACC_W+1-OUT_W){OUT_MIN[OUT_W-1]}}, OUT_MIN};

   logic signed [ACC_W:0]   round_s;
   logic signed [ACC_W:0]   sum_s;
   logic signed [ACC_W:0]   shifted_s;
   logic [OUT_W-1:0]        res_data_s;
   logic                    res_sat_s;

   logic [OUT_W-1:0]        data_q, data_d;
   logic                    vld_q,  vld_d;
   logic                    sat_q,  sat_d;

   // Round, shift, ReLU and saturate the incoming accumulator value.
   always_comb begin
      round_s    = {(ACC_W+1){1'b0}};
      res_data_s = {OUT_W{1'b0}};
      res_sat_s  = 1'b0;

      // Half an LSB of the shifted result; nothing to add for a zero shift.
      if (shift_i != {SHIFT_W{1'b0}}) begin
         round_s = {{ACC_W{1'b0}}, 1'b1} << (shift_i - {{(SHIFT_W-1){1'b0}}, 1'b1});
      end else begin
         round_s = {(ACC_W+1){1'b0}};
      end

      // One guard bit above ACC_W keeps the rounding add from wrapping.
      sum_s     = $signed({acc_i[ACC_W-1], acc_i}) + round_s;
      shifted_s = sum_s >>> shift_i;

      // ReLU zeroing is checked first so it never reports as saturation.
      if (relu_en_i && shifted_s[ACC_W]) begin
         res_data_s = {OUT_W{1'b0}};
         res_sat_s  = 1'b0;
      end else if (shifted_s > MAX_X) begin
         res_data_s = OUT_MAX;
         res_sat_s  = 1'b1;
      end else if (shifted_s < MIN_X) begin
         res_data_s = OUT_MIN;
         res_sat_s  = 1'b1;
      end else begin
         res_data_s = shifted_s[OUT_W-1:0];
         res_sat_s  = 1'b0;
      end
   end

   // Capture a new result on done, otherwise hold data/sat and drop valid.
   always_comb begin
      data_d = data_q;
      sat_d  = sat_q;
      vld_d  = 1'b0;
      if (done_i) begin
         data_d = res_data_s;
         sat_d  = res_sat_s;
         vld_d  = 1'b1;
      end else begin
         data_d = data_q;
         sat_d  = sat_q;
         vld_d  = 1'b0;
      end
   end

   // Output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         data_q <= {OUT_W{1'b0}};
         vld_q  <= 1'b0;
         sat_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         vld_q  <= vld_d;
         sat_q  <= sat_d;
      end
   end

   assign data_o = data_q;
   assign vld_o  = vld_q;
   assign sat_o  = sat_q;

endmodule : psum_requant

// File: rtl/psum_accumulator.sv
// -----------------------------------------------------------------------------
// psum_accumulator
// Accumulates num_ch consecutive signed partial sums (one per input channel)
// on top of a per-output bias, then hands the finished sum to psum_requant,
// which emits one quantised activation two cycles after the last partial sum.
// Sequences may run back to back with no idle cycle between them.
//
// Ports:
//   clk        in   clock, rising edge
//   rstn       in   asynchronous active-low reset
//   vld_i      in   1        partial sum valid
//   acc_i      in   IN_W     signed partial sum from the adder tree
//   num_ch_i   in   CNT_W    partial sums per output (0 treated as 1)
//   bias_i     in   BIAS_W   signed bias
//   shift_i    in   SHIFT_W  requant right shift 0..31
//   relu_en_i  in   1        clamp negative results to zero
//   clr_i      in   1        synchronous abort of the current sequence
//   data_o     out  OUT_W    signed quantised activation
//   vld_o      out  1        one-cycle pulse per output
//   sat_o      out  1        result clipped by saturation (with vld_o)
// -----------------------------------------------------------------------------
module psum_accumulator
   import psum_pkg::*;
#(
   parameter int IN_W  = psum_pkg::IN_W,
   parameter int ACC_W = psum_pkg::ACC_W,
   parameter int OUT_W = psum_pkg::OUT_W,
   parameter int CNT_W = psum_pkg::CNT_W
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                vld_i,
   input  logic [IN_W-1:0]     acc_i,
   input  logic [CNT_W-1:0]    num_ch_i,
   input  logic [BIAS_W-1:0]   bias_i,
   input  logic [SHIFT_W-1:0]  shift_i,
   input  logic                relu_en_i,
   input  logic                clr_i,
   output logic [OUT_W-1:0]    data_o,
   output logic                vld_o,
   output logic                sat_o
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0]          cnt_q,    cnt_d;
   logic [CNT_W-1:0]          num_ch_q, num_ch_d;
   logic [SHIFT_W-1:0]        shift_q,  shift_d;
   logic                      relu_q,   relu_d;
   logic signed [ACC_W-1:0]   acc_q,    acc_d;
   logic                      done_q,   done_d;

   logic                      start_s;
   logic                      last_s;
   logic [CNT_W-1:0]          num_ch_eff_s;
   logic signed [ACC_W-1:0]   acc_ext_s;
   logic signed [ACC_W-1:0]   bias_ext_s;
   logic                      rq_done_s;

   // Decode sequence start/end and sign-extend the incoming operands.
   always_comb begin
      start_s    = vld_i && (cnt_q == CNT_ZERO);
      acc_ext_s  = {{(ACC_W-IN_W){acc_i[IN_W-1]}}, acc_i};
      bias_ext_s = {{(ACC_W-BIAS_W){bias_i[BIAS_W-1]}}, bias_i};
      last_s     = 1'b0;

      // A channel count of zero means a single partial sum.
      if (num_ch_i == CNT_ZERO) begin
         num_ch_eff_s = CNT_ONE;
      end else begin
         num_ch_eff_s = num_ch_i;
      end

      // On the first partial sum the latched count is not valid yet, so
      // the live (effective) count decides whether start is also last.
      if (start_s) begin
         last_s = (num_ch_eff_s == CNT_ONE);
      end else begin
         last_s = (cnt_q == (num_ch_q - CNT_ONE));
      end
   end

   // Next state for counter, config latches, accumulator and done flag.
   always_comb begin
      cnt_d    = cnt_q;
      num_ch_d = num_ch_q;
      shift_d  = shift_q;
      relu_d   = relu_q;
      acc_d    = acc_q;
      done_d   = 1'b0;

      if (clr_i) begin
         // Abort wins over a simultaneous partial sum, which is dropped.
         cnt_d  = CNT_ZERO;
         done_d = 1'b0;
      end else if (vld_i) begin
         if (start_s) begin
            num_ch_d = num_ch_eff_s;
            shift_d  = shift_i;
            relu_d   = relu_en_i;
            acc_d    = bias_ext_s + acc_ext_s;
         end else begin
            acc_d    = acc_q + acc_ext_s;
         end

         if (last_s) begin
            cnt_d  = CNT_ZERO;
            done_d = 1'b1;
         end else begin
            cnt_d  = cnt_q + CNT_ONE;
            done_d = 1'b0;
         end
      end else begin
         cnt_d  = cnt_q;
         done_d = 1'b0;
      end
   end

   // Sequence state registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q    <= CNT_ZERO;
         num_ch_q <= CNT_ZERO;
         shift_q  <= {SHIFT_W{1'b0}};
         relu_q   <= 1'b0;
         acc_q    <= {ACC_W{1'b0}};
         done_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         num_ch_q <= num_ch_d;
         shift_q  <= shift_d;
         relu_q   <= relu_d;
         acc_q    <= acc_d;
         done_q   <= done_d;
      end
   end

   // A clear in the cycle after the last partial sum also cancels the
   // output that is about to be registered. The shift/relu latches still
   // hold the finishing sequence's values here, even if a new sequence
   // starts on the same edge.
   assign rq_done_s = done_q & ~clr_i;

   psum_requant #(
      .ACC_W   (ACC_W),
      .OUT_W   (OUT_W),
      .SHIFT_W (SHIFT_W)
   ) u_requant (
      .clk       (clk),
      .rstn      (rstn),
      .acc_i     (acc_q),
      .done_i    (rq_done_s),
      .shift_i   (shift_q),
      .relu_en_i (relu_q),
      .data_o    (data_o),
      .vld_o     (vld_o),
      .sat_o     (sat_o)
   );

endmodule : psum_accumulator

// File: tb/tb_psum_accumulator.sv
// -----------------------------------------------------------------------------
// tb_psum_accumulator
// Directed and randomised stimulus for psum_accumulator. A list-based model
// collects the partial sums of each sequence, and on completion computes the
// expected activation with plain integer arithmetic (floor division for the
// rounded shift). It also records the cycle in which the output must appear.
// A negedge monitor compares every cycle: pulse timing, data, sat, and
// hold behaviour.
// -----------------------------------------------------------------------------
module tb_psum_accumulator;
   import psum_pkg::*;

   logic                clk = 1'b0;
   logic                rstn;
   logic                vld_i;
   logic [IN_W-1:0]     acc_i;
   logic [CNT_W-1:0]    num_ch_i;
   logic [BIAS_W-1:0]   bias_i;
   logic [SHIFT_W-1:0]  shift_i;
   logic                relu_en_i;
   logic                clr_i;
   logic [OUT_W-1:0]    data_o;
   logic                vld_o;
   logic                sat_o;

   psum_accumulator dut (
      .clk       (clk),
      .rstn      (rstn),
      .vld_i     (vld_i),
      .acc_i     (acc_i),
      .num_ch_i  (num_ch_i),
      .bias_i    (bias_i),
      .shift_i   (shift_i),
      .relu_en_i (relu_en_i),
      .clr_i     (clr_i),
      .data_o    (data_o),
      .vld_o     (vld_o),
      .sat_o     (sat_o)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Edge counter: after rising edge n, cyc == n.
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [7:0] d;
      logic       s;
   } exp_t;

   exp_t       exp_q[$];
   int         m_vals[$];
   int         m_n;
   int         m_bias;
   int         m_s;
   bit         m_relu;
   logic [7:0] last_d = 8'd0;
   logic       last_s = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      tests++;
      assert (got === want) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h (cyc %0d)", tag, got, want, cyc);
      end
   endtask

   // Expected activation: floor((acc + half) / 2^s), ReLU, clip to int8.
   function automatic void quant(input longint acc, input int s, input bit relu,
                                 output logic [7:0] d, output logic sat);
      longint v, p, q;
      v = acc;
      if (s > 0) v = v + (longint'(1) << (s - 1));
      p = longint'(1) << s;
      q = v / p;
      if ((v % p) != 0 && v < 0) q = q - 1;
      sat = 1'b0;
      if (relu && q < 0) q = 0;
      if (q > 127) begin
         q = 127; sat = 1'b1;
      end else if (q < -128) begin
         q = -128; sat = 1'b1;
      end
      d = q[7:0];
   endfunction

   task automatic cfg(input int n, input int b, input int s, input bit r);
      num_ch_i  = n[CNT_W-1:0];
      bias_i    = b[BIAS_W-1:0];
      shift_i   = s[SHIFT_W-1:0];
      relu_en_i = r;
   endtask

   // Drive one cycle of input and update the reference model.
   task automatic step(input bit v, input int a, input bit c);
      exp_t   e;
      longint tot;
      vld_i = v;
      acc_i = a[IN_W-1:0];
      clr_i = c;
      if (c) begin
         m_vals.delete();
         // An output due on the edge that samples the clear is cancelled.
         if (exp_q.size() > 0 && exp_q[$].cyc == cyc + 1) exp_q.pop_back();
      end else if (v) begin
         if (m_vals.size() == 0) begin
            m_n    = (num_ch_i == 0) ? 1 : int'(num_ch_i);
            m_bias = int'($signed(bias_i));
            m_s    = int'(shift_i);
            m_relu = relu_en_i;
         end
         m_vals.push_back(a);
         if (m_vals.size() == m_n) begin
            tot = longint'(m_bias);
            foreach (m_vals[i]) tot += longint'(m_vals[i]);
            quant(tot, m_s, m_relu, e.d, e.s);
            e.cyc = cyc + 2;
            exp_q.push_back(e);
            m_vals.delete();
         end
      end
      @(posedge clk);
      #1;
      vld_i = 1'b0;
      clr_i = 1'b0;
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
   endtask

   function automatic int rnd_ps();
      if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 1048575)) - 524288;
      else                           return int'($urandom_range(0, 4000)) - 2000;
   endfunction

   // Per-cycle output monitor.
   always @(negedge clk) begin
      if (!rstn) begin
         chk("rst_vld",  vld_o,  32'd0);
         chk("rst_data", data_o, 32'd0);
         chk("rst_sat",  sat_o,  32'd0);
         last_d = 8'd0;
         last_s = 1'b0;
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         chk("out_cyc",  cyc,    exp_q[0].cyc);
         chk("out_vld",  vld_o,  32'd1);
         chk("out_data", data_o, exp_q[0].d);
         chk("out_sat",  sat_o,  exp_q[0].s);
         last_d = exp_q[0].d;
         last_s = exp_q[0].s;
         void'(exp_q.pop_front());
      end else begin
         chk("idle_vld",  vld_o,  32'd0);
         chk("hold_data", data_o, last_d);
         chk("hold_sat",  sat_o,  last_s);
      end
   end

   initial begin
      int n;
      rstn = 1'b0;
      vld_i = 1'b0; acc_i = '0; clr_i = 1'b0;
      cfg(0, 0, 0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_data", data_o, 32'd0);
      chk("reset_vld",  vld_o,  32'd0);
      chk("reset_sat",  sat_o,  32'd0);
      rstn = 1'b1;
      gap(1);

      // Basic three-channel sequence with bias: 10+100-50+20 = 80.
      cfg(3, 10, 0, 1'b0);
      step(1'b1, 100, 1'b0); step(1'b1, -50, 1'b0); step(1'b1, 20, 1'b0);
      gap(3);

      // Single channel, back to back, round-half-up with shift 4: 2, 1, -1.
      cfg(1, 0, 4, 1'b0);
      step(1'b1, 24, 1'b0); step(1'b1, 23, 1'b0); step(1'b1, -24, 1'b0);
      gap(3);

      // Saturation high, low, and ReLU zeroing (not saturation).
      cfg(2, 0, 0, 1'b0);
      step(1'b1, 500000, 1'b0); step(1'b1, 500000, 1'b0); gap(2);
      step(1'b1, -500000, 1'b0); step(1'b1, -500000, 1'b0); gap(2);
      cfg(2, 0, 0, 1'b1);
      step(1'b1, -500000, 1'b0); step(1'b1, -500000, 1'b0); gap(3);

      // Gaps between partial sums and config changes mid-sequence: 10.
      cfg(4, 0, 0, 1'b0);
      step(1'b1, 1, 1'b0);
      step(1'b1, 2, 1'b0); gap(3);
      cfg(1, 999, 7, 1'b1);
      step(1'b1, 3, 1'b0); gap(1);
      step(1'b1, 4, 1'b0); gap(3);

      // Clear together with the last partial sum, then a clean 5+5+5.
      cfg(3, 0, 0, 1'b0);
      step(1'b1, 5, 1'b0); step(1'b1, 5, 1'b0); step(1'b1, 5, 1'b1);
      gap(2);
      step(1'b1, 5, 1'b0); step(1'b1, 5, 1'b0); step(1'b1, 5, 1'b0);
      gap(3);

      // Clear in the cycle after the last partial sum kills the output.
      cfg(1, 0, 0, 1'b0);
      step(1'b1, 9, 1'b0); step(1'b0, 0, 1'b1);
      gap(3);

      // Asynchronous reset mid-sequence after a saturated output.
      cfg(2, 0, 0, 1'b0);
      step(1'b1, 500000, 1'b0); step(1'b1, 500000, 1'b0); gap(3);
      step(1'b1, 1, 1'b0);
      #2;
      rstn = 1'b0;
      exp_q.delete();
      m_vals.delete();
      #1;
      chk("async_rst_data", data_o, 32'd0);
      chk("async_rst_vld",  vld_o,  32'd0);
      chk("async_rst_sat",  sat_o,  32'd0);
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      cfg(0, 0, 0, 1'b0);
      step(1'b1, 7, 1'b0);
      gap(3);

      // Randomised sequences with gaps, mid-sequence bias noise and clears.
      for (int sq = 0; sq < 40; sq++) begin
         cfg(int'($urandom_range(0, 5)), int'($urandom_range(0, 65535)),
             int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
         n = (num_ch_i == 0) ? 1 : int'(num_ch_i);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) gap(int'($urandom_range(1, 2)));
            if ($urandom_range(0, 5) == 0) bias_i = BIAS_W'($urandom);
            step(1'b1, rnd_ps(), ($urandom_range(0, 29) == 0));
         end
         if ($urandom_range(0, 7) == 0) step(1'b0, 0, 1'b1);
      end

      // Drain outstanding outputs within a bounded number of cycles.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) gap(1);
      chk("drain_pending", exp_q.size(), 32'd0);
      gap(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_psum_accumulator
